mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit_pkg.sv | 29 ++
 rtl/mult_div_unit_arith.sv | 54 +++++
 rtl/mult_div_unit.sv | 119 +++++++++++
 tb/tb_mult_div_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared CPU package for the multiply/divide unit: op encodings, latencies,
// FSM state type and the HI/LO result payload.
package mult_div_unit_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned MULT_LAT = 5;
  localparam int unsigned DIV_LAT  = 10;
  localparam int unsigned CNT_W    = 4;

  // op field encodings (6-7 are no-ops)
  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  // {HI, LO} pair; HI occupies the upper half when viewed as 64 bits
  typedef struct packed {
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
  } hilo_t;

endpackage

// File: rtl/mult_div_unit_arith.sv
// mdu_arith: combinational product/quotient datapath.
// Ports: op (operation), a/b (operands), res_c ({HI,LO} result),
//        div_zero_c (divisor is zero; result must not be committed).
module mdu_arith
  import mult_div_unit_pkg::*;
(
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output hilo_t           res_c,
  output logic            div_zero_c
);

  logic signed [63:0] sa64;
  logic signed [63:0] sb64;
  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic [XLEN-1:0]    q_s, r_s, q_u, r_u;
  logic               div_ovf;

  // Products, quotients and result selection
  always_comb begin
    sa64       = {{32{a[31]}}, a};
    sb64       = {{32{b[31]}}, b};
    prod_s     = 64'(sa64 * sb64);
    prod_u     = {32'b0, a} * {32'b0, b};
    div_zero_c = (b == '0);
    div_ovf    = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    q_s        = '0;
    r_s        = '0;
    q_u        = '0;
    r_u        = '0;
    if (!div_zero_c) begin
      q_u = a / b;
      r_u = a % b;
      // INT_MIN / -1 wraps to INT_MIN with zero remainder
      if (div_ovf) begin
        q_s = 32'h8000_0000;
        r_s = '0;
      end else begin
        q_s = 32'($signed(a) / $signed(b));
        r_s = 32'($signed(a) % $signed(b));
      end
    end
    case (op)
      OP_MULT:  res_c = prod_s;
      OP_MULTU: res_c = prod_u;
      OP_DIV:   res_c = '{hi: r_s, lo: q_s};
      OP_DIVU:  res_c = '{hi: r_u, lo: q_u};
      default:  res_c = '0;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle MULT/MULTU/DIV/DIVU plus MTHI/MTLO with HI/LO.
// Ports: clk, reset (sync active-low), start/op/rs_val/rt_val (issue),
//        pc (trace only), busy, hi, lo.
// Optional: define MDU_TRACE_EN to print every HI/LO commit with its pc.
module mult_div_unit
  import mult_div_unit_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  input  logic [XLEN-1:0] pc,
  output logic            busy,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  mdu_state_e       state;
  logic [CNT_W-1:0] cnt;
  hilo_t            pend;
  logic             pend_wr;
  hilo_t            arith_res_c;
  logic             div_zero_c;

`ifdef MDU_TRACE_EN
  logic [XLEN-1:0]  pend_pc;
`else
  logic             unused_pc;
  assign unused_pc = ^pc;
`endif

  mdu_arith u_arith (
    .op         (op),
    .a          (rs_val),
    .b          (rt_val),
    .res_c      (arith_res_c),
    .div_zero_c (div_zero_c)
  );

  // FSM, latency counter, pending result and architectural HI/LO
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      cnt     <= '0;
      pend    <= '0;
      pend_wr <= 1'b0;
      hi      <= '0;
      lo      <= '0;
`ifdef MDU_TRACE_EN
      pend_pc <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                pend    <= arith_res_c;
                pend_wr <= 1'b1;
                cnt     <= CNT_W'(MULT_LAT);
                state   <= ST_RUN;
                busy    <= 1'b1;
`ifdef MDU_TRACE_EN
                pend_pc <= pc;
`endif
              end
              OP_DIV, OP_DIVU: begin
                pend    <= arith_res_c;
                pend_wr <= !div_zero_c;
                cnt     <= CNT_W'(DIV_LAT);
                state   <= ST_RUN;
                busy    <= 1'b1;
`ifdef MDU_TRACE_EN
                pend_pc <= pc;
`endif
              end
              OP_MTHI: begin
                hi <= rs_val;
`ifdef MDU_TRACE_EN
                $display("@%h: HI <= %h", pc, rs_val);
`endif
              end
              OP_MTLO: begin
                lo <= rs_val;
`ifdef MDU_TRACE_EN
                $display("@%h: LO <= %h", pc, rs_val);
`endif
              end
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          // cnt==1 marks the Nth edge after accept: commit and drop busy
          if (cnt == CNT_W'(1)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
            if (pend_wr) begin
              hi <= pend.hi;
              lo <= pend.lo;
`ifdef MDU_TRACE_EN
              $display("@%h: HI <= %h", pend_pc, pend.hi);
              $display("@%h: LO <= %h", pend_pc, pend.lo);
`endif
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus
// randomized traffic against a cycle-level behavioural model.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] pc;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  int          m_left;
  bit          m_pwr;
  logic [31:0] pc_r;

  mult_div_unit dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .pc     (pc),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // {hi, lo} from plain 64-bit arithmetic; divisor assumed nonzero for div ops
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    int              ia, ib;
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    ia = a; ib = b;
    sa = ia; sb = ib;
    ua = {32'b0, a}; ub = {32'b0, b};
    case (o)
      3'd0:    return 64'(sa * sb);
      3'd1:    return ua * ub;
      3'd2: begin
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: return {32'(ua % ub), 32'(ua / ub)};
    endcase
  endfunction

  task automatic model_step(input logic rst, input logic st, input logic [2:0] o,
                            input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    if (!rst) begin
      m_hi = 0; m_lo = 0; m_left = 0; m_pwr = 0; m_phi = 0; m_plo = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_pwr) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
    end else if (st) begin
      if (o <= 3'd1) begin
        r = ref_result(o, a, b);
        {m_phi, m_plo} = r;
        m_pwr  = 1;
        m_left = 5;
      end else if (o <= 3'd3) begin
        m_pwr  = (b != 0);
        if (m_pwr) {m_phi, m_plo} = ref_result(o, a, b);
        m_left = 10;
      end else if (o == 3'd4) begin
        m_hi = a;
      end else if (o == 3'd5) begin
        m_lo = a;
      end
    end
  endtask

  // drive one cycle, update the model at the edge, compare just after it
  task automatic tick(input logic rst, input logic st, input logic [2:0] o,
                      input logic [31:0] a, input logic [31:0] b);
    reset = rst; start = st; op = o; rs_val = a; rt_val = b;
    pc = pc_r; pc_r += 32'd4;
    @(posedge clk);
    model_step(rst, st, o, a, b);
    #1;
    chk("busy", 32'(busy), 32'(m_left > 0));
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
  endtask

  task automatic idle_count(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      n += int'(busy);
      tick(1'b1, 1'b0, 3'd0, 32'h0, 32'h0);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h1;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    pc_r = 32'h0040_0000;
    m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_left = 0; m_pwr = 0;
    reset = 0; start = 0; op = 0; rs_val = 0; rt_val = 0; pc = 0;

    tick(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    tick(1'b0, 1'b1, OP_MTHI, 32'h5555_5555, 32'h0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);

    // MULT -2 * 3
    tick(1'b1, 1'b1, OP_MULT, 32'hFFFF_FFFE, 32'd3);
    idle_count(5, n);
    chk("mult_busy_cycles", 32'(n), 32'd5);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);

    // MULTU 0xFFFFFFFF * 2
    tick(1'b1, 1'b1, OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    idle_count(5, n);
    chk("multu_busy_cycles", 32'(n), 32'd5);
    chk("multu_hi", hi, 32'h0000_0001);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    // DIV -7 / 2
    tick(1'b1, 1'b1, OP_DIV, 32'hFFFF_FFF9, 32'd2);
    idle_count(10, n);
    chk("div_busy_cycles", 32'(n), 32'd10);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    chk("div_lo", lo, 32'hFFFF_FFFD);

    // DIVU 7 / 0 leaves HI/LO alone
    tick(1'b1, 1'b1, OP_DIVU, 32'd7, 32'd0);
    idle_count(10, n);
    chk("divz_busy_cycles", 32'(n), 32'd10);
    chk("divz_hi", hi, 32'hFFFF_FFFF);
    chk("divz_lo", lo, 32'hFFFF_FFFD);

    // DIV INT_MIN / -1
    tick(1'b1, 1'b1, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    idle_count(10, n);
    chk("divovf_hi", hi, 32'h0);
    chk("divovf_lo", lo, 32'h8000_0000);

    // MTHI issued while MULT busy is dropped
    tick(1'b1, 1'b1, OP_MULT, 32'd7, 32'd6);
    tick(1'b1, 1'b0, 3'd0, 32'h0, 32'h0);
    tick(1'b1, 1'b1, OP_MTHI, 32'hDEAD_BEEF, 32'h0);
    idle_count(3, n);
    chk("busy_ign_hi", hi, 32'h0);
    chk("busy_ign_lo", lo, 32'd42);
    chk("busy_ign_busy", 32'(busy), 32'h0);

    // reset mid-DIV aborts the result
    tick(1'b1, 1'b1, OP_MTHI, 32'hCAFE_0001, 32'h0);
    tick(1'b1, 1'b1, OP_DIV, 32'd100, 32'd7);
    idle_count(3, n);
    tick(1'b0, 1'b1, OP_MTLO, 32'h1111_1111, 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_hi", hi, 32'h0);
    chk("abort_lo", lo, 32'h0);
    idle_count(12, n);
    chk("abort_nobusy", 32'(n), 32'd0);
    chk("abort_late_lo", lo, 32'h0);

    // MTLO while idle, then no-op codes
    tick(1'b1, 1'b1, OP_MTLO, 32'h1234_5678, 32'h0);
    chk("mtlo_lo", lo, 32'h1234_5678);
    chk("mtlo_busy", 32'(busy), 32'h0);
    tick(1'b1, 1'b1, 3'd6, 32'hAAAA_AAAA, 32'd3);
    tick(1'b1, 1'b1, 3'd7, 32'hBBBB_BBBB, 32'd3);
    chk("nop_lo", lo, 32'h1234_5678);
    chk("nop_busy", 32'(busy), 32'h0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      tick(($urandom_range(0, 99) != 0), ($urandom_range(0, 2) != 0),
           3'($urandom_range(0, 7)), pick(), pick());
    end
    idle_count(12, n);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
